// File: rtl/ic_qz_ctrl.sv
// JPEG quantizer controller: feeds coefficients and reciprocals to an external multiplier and rounds the products.
// Define IC_QZ_CLAMP_EN to saturate quantized outputs to [-2047, 2047].
module ic_qz_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [5:0]  qt_addr,
    input  logic [12:0] qt_data,
    output logic [15:0] mult_dataa,
    output logic [12:0] mult_datab,
    output logic        mult_clken,
    input  logic [28:0] mult_result,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [5:0]  out_addr,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;

    logic [15:0] op_a_q, op_a_d;
    logic [12:0] op_b_q, op_b_d;
    logic [5:0]  op_zz_q, op_zz_d;
    logic        op_valid_q, op_valid_d;

    logic [5:0]  mul_zz_q, mul_zz_d;
    logic        mul_valid_q, mul_valid_d;

    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic [5:0]  out_addr_q, out_addr_d;

    logic        stall;
    logic        accept;
    logic signed [29:0] rounded_sum;
    logic signed [17:0] rounded;
    logic [15:0] quant;

    function automatic logic [5:0] zigzag(input logic [5:0] idx);
        zigzag = 6'd0;
        case (idx)
            6'd0:  zigzag = 6'd0;
            6'd1:  zigzag = 6'd1;
            6'd2:  zigzag = 6'd5;
            6'd3:  zigzag = 6'd6;
            6'd4:  zigzag = 6'd14;
            6'd5:  zigzag = 6'd15;
            6'd6:  zigzag = 6'd27;
            6'd7:  zigzag = 6'd28;
            6'd8:  zigzag = 6'd2;
            6'd9:  zigzag = 6'd4;
            6'd10: zigzag = 6'd7;
            6'd11: zigzag = 6'd13;
            6'd12: zigzag = 6'd16;
            6'd13: zigzag = 6'd26;
            6'd14: zigzag = 6'd29;
            6'd15: zigzag = 6'd42;
            6'd16: zigzag = 6'd3;
            6'd17: zigzag = 6'd8;
            6'd18: zigzag = 6'd12;
            6'd19: zigzag = 6'd17;
            6'd20: zigzag = 6'd25;
            6'd21: zigzag = 6'd30;
            6'd22: zigzag = 6'd41;
            6'd23: zigzag = 6'd43;
            6'd24: zigzag = 6'd9;
            6'd25: zigzag = 6'd11;
            6'd26: zigzag = 6'd18;
            6'd27: zigzag = 6'd24;
            6'd28: zigzag = 6'd31;
            6'd29: zigzag = 6'd40;
            6'd30: zigzag = 6'd44;
            6'd31: zigzag = 6'd53;
            6'd32: zigzag = 6'd10;
            6'd33: zigzag = 6'd19;
            6'd34: zigzag = 6'd23;
            6'd35: zigzag = 6'd32;
            6'd36: zigzag = 6'd39;
            6'd37: zigzag = 6'd45;
            6'd38: zigzag = 6'd52;
            6'd39: zigzag = 6'd54;
            6'd40: zigzag = 6'd20;
            6'd41: zigzag = 6'd22;
            6'd42: zigzag = 6'd33;
            6'd43: zigzag = 6'd38;
            6'd44: zigzag = 6'd46;
            6'd45: zigzag = 6'd51;
            6'd46: zigzag = 6'd55;
            6'd47: zigzag = 6'd60;
            6'd48: zigzag = 6'd21;
            6'd49: zigzag = 6'd34;
            6'd50: zigzag = 6'd37;
            6'd51: zigzag = 6'd47;
            6'd52: zigzag = 6'd50;
            6'd53: zigzag = 6'd56;
            6'd54: zigzag = 6'd59;
            6'd55: zigzag = 6'd61;
            6'd56: zigzag = 6'd35;
            6'd57: zigzag = 6'd36;
            6'd58: zigzag = 6'd48;
            6'd59: zigzag = 6'd49;
            6'd60: zigzag = 6'd57;
            6'd61: zigzag = 6'd58;
            6'd62: zigzag = 6'd62;
            6'd63: zigzag = 6'd63;
        endcase
    endfunction

    // A full output register that downstream refuses freezes the whole pipe, external multiplier included.
    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = (state_q == RUN) && !stall;
    assign accept     = in_valid && in_ready;
    assign mult_clken = !stall;

    assign qt_addr    = count_q;
    assign mult_dataa = op_a_q;
    assign mult_datab = op_b_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    always_comb begin
        rounded_sum = $signed({mult_result[28], mult_result}) + 30'sd2048;
        rounded     = rounded_sum[29:12];
`ifdef IC_QZ_CLAMP_EN
        if (rounded > 18'sd2047) begin
            quant = 16'sd2047;
        end else if (rounded < -18'sd2047) begin
            quant = -16'sd2047;
        end else begin
            quant = rounded[15:0];
        end
`else
        quant = rounded[15:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = 6'd0;
                end
            end
            RUN: begin
                if (accept) begin
                    count_d = count_q + 6'd1;
                    if (count_q == 6'd63) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!op_valid_q && !mul_valid_q && !out_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid bits and zigzag index ride alongside the data through the multiplier latency.
    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_zz_d     = op_zz_q;
        op_valid_d  = op_valid_q;
        mul_zz_d    = mul_zz_q;
        mul_valid_d = mul_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        if (!stall) begin
            op_valid_d = accept;
            if (accept) begin
                op_a_d  = in_data;
                op_b_d  = qt_data;
                op_zz_d = zigzag(count_q);
            end
            mul_valid_d = op_valid_q;
            mul_zz_d    = op_zz_q;
            out_valid_d = mul_valid_q;
            if (mul_valid_q) begin
                out_data_d = quant;
                out_addr_d = mul_zz_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= 6'd0;
            op_a_q      <= 16'd0;
            op_b_q      <= 13'd0;
            op_zz_q     <= 6'd0;
            op_valid_q  <= 1'b0;
            mul_zz_q    <= 6'd0;
            mul_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'd0;
            out_addr_q  <= 6'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_zz_q     <= op_zz_d;
            op_valid_q  <= op_valid_d;
            mul_zz_q    <= mul_zz_d;
            mul_valid_q <= mul_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

endmodule

// File: tb/tb_ic_qz_ctrl.sv
// Scoreboard bench for ic_qz_ctrl with a behavioural registered multiplier and reciprocal table.
// Expected quantized values follow whether IC_QZ_CLAMP_EN is defined.
module tb_ic_qz_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_ready;
    logic [5:0]  qt_addr;
    logic [12:0] qt_data;
    logic [15:0] mult_dataa;
    logic [12:0] mult_datab;
    logic        mult_clken;
    logic [28:0] mult_result = 29'd0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [5:0]  out_addr;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        popped;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          idx = 0;
    int          out_count = 0;
    int          done_count = 0;
    int          first_acc_cycle = 0;
    int          first_out_cycle = 0;
    logic [63:0] seen_mask = '0;
    int          zz_model[64];
    logic [15:0] coef_mem[64];
    logic [15:0] expv_mem[64];
    logic [12:0] qt_mem[64];

    ic_qz_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .qt_addr     (qt_addr),
        .qt_data     (qt_data),
        .mult_dataa  (mult_dataa),
        .mult_datab  (mult_datab),
        .mult_clken  (mult_clken),
        .mult_result (mult_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    assign qt_data = qt_mem[qt_addr];

    // Registered signed multiplier, advancing only when enabled.
    always @(posedge clock) begin
        if (mult_clken) begin
            mult_result <= $signed({{13{mult_dataa[15]}}, mult_dataa}) *
                           $signed({{16{mult_datab[12]}}, mult_datab});
        end
    end

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every accepted output is popped from the scoreboard in order.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (out_count == 0) first_out_cycle = cycle;
            out_count++;
            seen_mask[out_addr] = 1'b1;
            if (exp_q.size() == 0) begin
                check_output("unexpected_output", exp_q.size(), 1);
            end else begin
                popped = exp_q.pop_front();
                check_output("out_data", $signed(out_data), $signed(popped.data));
                check_output("out_addr", {26'd0, out_addr}, {26'd0, popped.addr});
            end
        end
        if (reset_n && done) done_count++;
    end

    task automatic apply_stimulus(input logic [15:0] d, input logic [15:0] expv);
        int guard;
        guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            check_output("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        check_output("count", {26'd0, qt_addr}, idx);
        if (idx == 0) first_acc_cycle = cycle;
        exp_q.push_back('{data: expv, addr: 6'(zz_model[idx])});
        idx++;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_block(input int n);
        out_count  = 0;
        done_count = 0;
        seen_mask  = '0;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < n; i++) apply_stimulus(coef_mem[i], expv_mem[i]);
    endtask

    task automatic finish_block();
        int guard;
        guard = 0;
        while (done_count == 0 && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        check_output("done_seen", done_count, 1);
        repeat (3) @(negedge clock);
        check_output("done_pulses", done_count, 1);
        check_output("busy_after_done", busy, 0);
        check_output("out_count", out_count, 64);
        check_output("queue_empty", exp_q.size(), 0);
        check_output("addr_permutation", (seen_mask == {64{1'b1}}), 1);
    endtask

    task automatic fill_uniform();
        for (int i = 0; i < 64; i++) begin
            coef_mem[i] = 16'sd100;
            expv_mem[i] = 16'sd6;
            qt_mem[i]   = 13'd256;
        end
    endtask

    // Holds downstream off for five cycles; the held output must be the oldest pending result.
    task automatic stall_window();
        int guard;
        guard = 0;
        while (idx < 30 && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_output("stall_out_valid", out_valid, 1);
            check_output("stall_in_ready", in_ready, 0);
            check_output("stall_clken", mult_clken, 0);
            check_output("stall_hold_data", $signed(out_data), $signed(exp_q[0].data));
            check_output("stall_hold_addr", {26'd0, out_addr}, {26'd0, exp_q[0].addr});
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
    endtask

    task automatic start_glitch();
        int guard;
        guard = 0;
        while (idx < 40 && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    initial begin
        int pos;
        int r_lo;
        int r_hi;
        pos = 0;
        for (int s = 0; s < 15; s++) begin
            r_lo = (s > 7) ? s - 7 : 0;
            r_hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = r_hi; r >= r_lo; r--) begin
                    zz_model[r * 8 + (s - r)] = pos;
                    pos++;
                end
            end else begin
                for (int r = r_lo; r <= r_hi; r++) begin
                    zz_model[r * 8 + (s - r)] = pos;
                    pos++;
                end
            end
        end
        fill_uniform();

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_data", {16'd0, out_data}, 0);
        check_output("rst_out_addr", {26'd0, out_addr}, 0);
        check_output("rst_dataa", {16'd0, mult_dataa}, 0);
        check_output("rst_datab", {19'd0, mult_datab}, 0);
        check_output("rst_in_ready", in_ready, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_count", {26'd0, qt_addr}, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        $display("[TB] basic block");
        idx = 0;
        run_block(64);
        finish_block();
        check_output("latency", first_out_cycle - first_acc_cycle, 3);

        $display("[TB] rounding, clamp, backpressure and start-in-RUN block");
        fill_uniform();
        coef_mem[5]  = 16'sd32767;
        qt_mem[5]    = 13'd4095;
        coef_mem[13] = -16'sd32768;
        qt_mem[13]   = 13'd4095;
`ifdef IC_QZ_CLAMP_EN
        expv_mem[5]  = 16'sd2047;
        expv_mem[13] = -16'sd2047;
`else
        expv_mem[5]  = 16'sd32759;
        expv_mem[13] = -16'sd32760;
`endif
        coef_mem[10] = 16'sd8;
        expv_mem[10] = 16'sd1;
        coef_mem[11] = -16'sd8;
        expv_mem[11] = 16'sd0;
        coef_mem[12] = -16'sd24;
        expv_mem[12] = -16'sd1;
        coef_mem[56] = -16'sd100;
        expv_mem[56] = -16'sd6;
        idx = 0;
        fork
            run_block(64);
            stall_window();
            start_glitch();
        join
        finish_block();

        $display("[TB] reset mid-block");
        fill_uniform();
        idx = 0;
        run_block(20);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_in_ready", in_ready, 0);
        check_output("midrst_count", {26'd0, qt_addr}, 0);
        exp_q.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_output("post_rst_quiet", out_valid, 0);
        end
        idx = 0;
        run_block(64);
        finish_block();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
